// File: rtl/ps2_dev_tx.sv
// PS/2 device-side transmitter: FIFO-buffered words sent as start/data/parity/stop frames.
// Define PS2_DEV_TX_INHIBIT_EN to add host-inhibit detection (abort and full-frame resend).
module ps2_dev_tx #(
  parameter int DW      = 8,
  parameter int PARITY  = 1,
  parameter int QUARTER = 2,
  parameter int IDLE_Q  = 4,
  parameter int DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DW-1:0]          in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy,
  output logic                   kclk_o,
  output logic                   kdat_o,
  input  logic                   kclk_i,
  output logic                   abort
);

  localparam int NBITS = DW + 2 + ((PARITY != 0) ? 1 : 0);
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int GAPN  = (IDLE_Q * QUARTER > 0) ? IDLE_Q * QUARTER : 1;
  localparam int TW    = (QUARTER > 1) ? $clog2(QUARTER) : 1;
  localparam int GW    = (GAPN > 1) ? $clog2(GAPN) : 1;
  localparam int BW    = $clog2(NBITS);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GAP   = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
`ifdef PS2_DEV_TX_INHIBIT_EN
  localparam logic [1:0] ST_INHIBIT = 2'd3;
`endif

  // FIFO storage
  logic [DW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_reg;
  logic [DW-1:0]    head_reg;
  logic             wr_en;
  logic             pop;

  // frame sequencer
  logic [1:0]       state_reg;
  logic [TW-1:0]    tick_reg;
  logic [1:0]       qtr_reg;
  logic [BW-1:0]    cell_reg;
  logic [GW-1:0]    gap_reg;
  logic [NBITS-1:0] shift_reg;
  logic [NBITS-1:0] frame_word;
  logic             kclk_reg;
  logic             kdat_reg;
  logic             par_bit;
  logic             tick_end;
  logic             last_cell;
  logic             cell_end;
  logic             hold_lines;

  assign in_ready = (count_reg < CW'(DEPTH));
  assign wr_en    = in_valid && in_ready;
  assign count    = count_reg;
  assign busy     = (state_reg != ST_IDLE);
  assign kclk_o   = kclk_reg;
  assign kdat_o   = kdat_reg;

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= in_data;
    head_reg <= mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_reg <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !pop)
        count_reg <= count_reg + 1'b1;
      else if (pop && !wr_en)
        count_reg <= count_reg - 1'b1;
    end
  end

  assign par_bit = (PARITY == 2) ? (^head_reg) : ~(^head_reg);

  generate
    if (PARITY != 0) begin : g_par
      assign frame_word = {1'b1, par_bit, head_reg, 1'b0};
    end else begin : g_nopar
      assign frame_word = {1'b1, head_reg, 1'b0};
    end
  endgenerate

  assign tick_end  = (tick_reg == TW'(QUARTER - 1));
  assign last_cell = (cell_reg == BW'(NBITS - 1));
  assign cell_end  = (state_reg == ST_SHIFT) && tick_end && (qtr_reg == 2'd3) && last_cell;

`ifdef PS2_DEV_TX_INHIBIT_EN
  logic [1:0] sync_reg;
  logic       kclk_s;
  logic       inhibit_hit;
  logic       abort_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sync_reg <= 2'b11;
    else
      sync_reg <= {sync_reg[0], kclk_i};
  end

  assign kclk_s      = sync_reg[1];
  assign hold_lines  = ~kclk_s;
  // Only a low line while we are releasing the clock can be the host.
  assign inhibit_hit = (state_reg == ST_SHIFT) && hold_lines && kclk_reg;
  assign pop         = cell_end && !inhibit_hit;
  assign abort       = abort_reg;
`else
  logic unused_kclk;
  assign unused_kclk = kclk_i;
  assign hold_lines  = 1'b0;
  assign pop         = cell_end;
  assign abort       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      tick_reg  <= '0;
      qtr_reg   <= '0;
      cell_reg  <= '0;
      gap_reg   <= '0;
      shift_reg <= '0;
      kclk_reg  <= 1'b1;
      kdat_reg  <= 1'b1;
`ifdef PS2_DEV_TX_INHIBIT_EN
      abort_reg <= 1'b0;
`endif
    end else begin
`ifdef PS2_DEV_TX_INHIBIT_EN
      abort_reg <= 1'b0;
`endif
      case (state_reg)
        ST_IDLE: begin
          kclk_reg <= 1'b1;
          kdat_reg <= 1'b1;
          gap_reg  <= '0;
          if ((count_reg != '0) && !hold_lines)
            state_reg <= ST_GAP;
        end
        ST_GAP: begin
          if (hold_lines) begin
            gap_reg <= '0;
          end else if (gap_reg == GW'(GAPN - 1)) begin
            state_reg <= ST_SHIFT;
            shift_reg <= frame_word;
            tick_reg  <= '0;
            qtr_reg   <= '0;
            cell_reg  <= '0;
          end else begin
            gap_reg <= gap_reg + 1'b1;
          end
        end
        ST_SHIFT: begin
`ifdef PS2_DEV_TX_INHIBIT_EN
          if (inhibit_hit) begin
            abort_reg <= 1'b1;
            kclk_reg  <= 1'b1;
            kdat_reg  <= 1'b1;
            gap_reg   <= '0;
            state_reg <= ST_INHIBIT;
          end else
`endif
          if (tick_end) begin
            tick_reg <= '0;
            qtr_reg  <= qtr_reg + 2'd1;
            // Data moves at Q1 and the clock falls at Q2, so data is stable while clock is low.
            case (qtr_reg)
              2'd0: kdat_reg <= shift_reg[0];
              2'd1: kclk_reg <= 1'b0;
              2'd3: begin
                kclk_reg  <= 1'b1;
                shift_reg <= shift_reg >> 1;
                cell_reg  <= cell_reg + 1'b1;
                if (last_cell)
                  state_reg <= ST_IDLE;
              end
              default: ;
            endcase
          end else begin
            tick_reg <= tick_reg + 1'b1;
          end
        end
`ifdef PS2_DEV_TX_INHIBIT_EN
        ST_INHIBIT: begin
          // Head word is still queued; resend it in full once the host lets go.
          if (hold_lines) begin
            gap_reg <= '0;
          end else if (gap_reg == GW'(GAPN - 1)) begin
            gap_reg   <= '0;
            state_reg <= ST_GAP;
          end else begin
            gap_reg <= gap_reg + 1'b1;
          end
        end
`endif
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
